// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, ALU control-bit positions, sequencer state and decode types
// for the ALU operation sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_CLR  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_MUL  = 4'd3;
  localparam logic [3:0] OP_DIV  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_ASL  = 4'd7;
  localparam logic [3:0] OP_ASR  = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_OR   = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_XOR  = 4'd12;
  localparam logic [3:0] OP_XNOR = 4'd13;
  localparam logic [3:0] OP_LDB  = 4'd14;
  localparam logic [3:0] OP_ILL  = 4'd15;

  localparam int B_CLR  = 8;
  localparam int B_ADD  = 9;
  localparam int B_SUB  = 15;
  localparam int B_MUL  = 16;
  localparam int B_DIV  = 17;
  localparam int B_SHL  = 18;
  localparam int B_SHR  = 19;
  localparam int B_ASL  = 20;
  localparam int B_ASR  = 21;
  localparam int B_AND  = 22;
  localparam int B_OR   = 23;
  localparam int B_NOT  = 24;
  localparam int B_XOR  = 25;
  localparam int B_XNOR = 26;
  localparam int B_LDBR = 28;

  localparam logic [31:0] LDBR_WORD = 32'h1000_0000;

  typedef enum logic [2:0] {S_IDLE, S_LOADBR, S_EXEC, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {LAT_NONE, LAT_MUL, LAT_DIV} lat_sel_t;

  typedef struct packed {
    logic [31:0] op_word;
    logic        binary;
    logic        ldb;
    logic        illegal;
    lat_sel_t    lat_sel;
  } dec_t;

  // Ops that consume BR and therefore need a load before the strobe.
  function automatic logic is_binary(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV,
      OP_AND, OP_OR, OP_XOR, OP_XNOR: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Opcode decode: one-hot ALU strobe word plus class flags and latency select.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  always_comb begin
    dec         = '0;
    dec.binary  = is_binary(op);
    dec.ldb     = (op == OP_LDB);
    dec.illegal = (op == OP_ILL);
    dec.lat_sel = LAT_NONE;
    case (op)
      OP_CLR:  dec.op_word[B_CLR]  = 1'b1;
      OP_ADD:  dec.op_word[B_ADD]  = 1'b1;
      OP_SUB:  dec.op_word[B_SUB]  = 1'b1;
      OP_MUL:  begin dec.op_word[B_MUL] = 1'b1; dec.lat_sel = LAT_MUL; end
      OP_DIV:  begin dec.op_word[B_DIV] = 1'b1; dec.lat_sel = LAT_DIV; end
      OP_SHL:  dec.op_word[B_SHL]  = 1'b1;
      OP_SHR:  dec.op_word[B_SHR]  = 1'b1;
      OP_ASL:  dec.op_word[B_ASL]  = 1'b1;
      OP_ASR:  dec.op_word[B_ASR]  = 1'b1;
      OP_AND:  dec.op_word[B_AND]  = 1'b1;
      OP_OR:   dec.op_word[B_OR]   = 1'b1;
      OP_NOT:  dec.op_word[B_NOT]  = 1'b1;
      OP_XOR:  dec.op_word[B_XOR]  = 1'b1;
      OP_XNOR: dec.op_word[B_XNOR] = 1'b1;
      OP_LDB:  dec.op_word[B_LDBR] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU operation sequencer: BR load, op strobe, settle wait, then a held
// response carrying ACC, high word and sign flag.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 0,
  parameter int DIV_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [15:0] req_operand,
  output logic [31:0] control_signal,
  output logic [15:0] br_out,
  input  logic        alu_flag,
  input  logic [15:0] alu_high,
  input  logic [15:0] alu_low,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_acc,
  output logic [15:0] rsp_high,
  output logic        rsp_flag,
  output logic        rsp_err,
  output logic        busy
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  state_t     state;
  logic [3:0] op_q;
  logic [3:0] cnt;
  logic [3:0] dec_op;
  logic [3:0] lat_cnt;
  dec_t       dec;

  // In IDLE the decoder looks at the incoming opcode so the first control
  // word can be registered on the accept edge; afterwards it sees the latch.
  assign dec_op = (state == S_IDLE) ? req_op : op_q;

  alu_op_decode u_dec (
    .op  (dec_op),
    .dec (dec)
  );

  always_comb begin
    case (dec.lat_sel)
      LAT_MUL: lat_cnt = MUL_CNT;
      LAT_DIV: lat_cnt = DIV_CNT;
      default: lat_cnt = 4'd0;
    endcase
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      op_q           <= '0;
      cnt            <= '0;
      control_signal <= '0;
      br_out         <= '0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_acc        <= '0;
      rsp_high       <= '0;
      rsp_flag       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q   <= req_op;
            br_out <= req_operand;
            if (dec.illegal) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_acc   <= alu_low;
              rsp_high  <= alu_high;
              rsp_flag  <= alu_flag;
            end else if (dec.binary || dec.ldb) begin
              state          <= S_LOADBR;
              control_signal <= LDBR_WORD;
            end else begin
              state          <= S_EXEC;
              control_signal <= dec.op_word;
            end
          end
        end
        S_LOADBR: begin
          if (dec.ldb) begin
            state          <= S_WAIT;
            control_signal <= '0;
            cnt            <= '0;
          end else begin
            state          <= S_EXEC;
            control_signal <= dec.op_word;
          end
        end
        S_EXEC: begin
          state          <= S_WAIT;
          control_signal <= '0;
          cnt            <= lat_cnt;
        end
        S_WAIT: begin
          // ACC was already updated on the EXEC edge, so a zero count captures now.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_acc   <= alu_low;
            rsp_high  <= alu_high;
            rsp_flag  <= alu_flag;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Random and directed checks of alu_ctrl_seq against an ALU model and an
// opcode-level reference of ACC/high/BR plus expected control timing.
module tb_alu_ctrl_seq;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 3;
  localparam int OPBIT [14] = '{8, 9, 15, 16, 17, 18, 19, 20, 21, 22, 23, 24, 25, 26};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_operand;
  logic [31:0] control_signal;
  logic [15:0] br_out;
  logic        alu_flag;
  logic [15:0] alu_high = '0, alu_low = '0, alu_br = '0;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_acc, rsp_high;
  logic        rsp_flag, rsp_err, busy;

  int n_chk = 0, n_fail = 0;
  logic [15:0] ref_acc = '0, ref_high = '0, ref_br = '0;

  always #5 clk = ~clk;

  alu_ctrl_seq #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_operand(req_operand),
    .control_signal(control_signal), .br_out(br_out),
    .alu_flag(alu_flag), .alu_high(alu_high), .alu_low(alu_low),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_acc(rsp_acc), .rsp_high(rsp_high), .rsp_flag(rsp_flag), .rsp_err(rsp_err),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ALU result for an opcode as {high, acc}.
  function automatic logic [31:0] op_res(input int op, input logic [15:0] a, input logic [15:0] h,
                                         input logic [15:0] b);
    logic [15:0] r;
    logic [31:0] p;
    r = a;
    case (op)
      1:  r = a + b;
      2:  r = a - b;
      5:  r = {a[14:0], 1'b0};
      6:  r = {1'b0, a[15:1]};
      7:  r = {a[14:0], 1'b0};
      8:  r = {a[15], a[15:1]};
      9:  r = a & b;
      10: r = a | b;
      11: r = ~a;
      12: r = a ^ b;
      13: r = ~(a ^ b);
      default: ;
    endcase
    p = {h, r};
    if (op == 0) p = '0;
    if (op == 3) p = {16'h0, a} * {16'h0, b};
    if (op == 4) p = (b == 16'h0) ? {a, 16'hFFFF} : {a % b, a / b};
    return p;
  endfunction

  // Behavioural ALU: reacts to whichever control bit is set on the edge.
  assign alu_flag = alu_low[15];
  always @(posedge clk) begin
    if (control_signal[28]) alu_br <= br_out;
    for (int i = 0; i < 14; i++)
      if (control_signal[OPBIT[i]]) {alu_high, alu_low} <= op_res(i, alu_low, alu_high, alu_br);
  end

  always @(negedge clk)
    if (rst_n) chk("onehot", 32'($countones(control_signal) <= 1), 32'd1);

  function automatic bit is_bin(input int op);
    return op inside {1, 2, 3, 4, 9, 10, 12, 13};
  endfunction

  function automatic int exp_lat(input int op);
    if (op == 15) return 1;
    if (op == 14) return 3;
    if (is_bin(op)) return 4 + (op == 3 ? MUL_LAT : 0) + (op == 4 ? DIV_LAT : 0);
    return 3;
  endfunction

  // Expected control word sampled k half-cycles-before-edge after acceptance.
  function automatic logic [31:0] exp_ctrl(input int op, input int k);
    if (op == 15) return 32'h0;
    if (is_bin(op) || op == 14) begin
      if (k == 1) return 32'h1000_0000;
      if (k == 2 && op != 14) return 32'h1 << OPBIT[op];
      return 32'h0;
    end
    return (k == 1) ? (32'h1 << OPBIT[op]) : 32'h0;
  endfunction

  task automatic accept(input int op, input logic [15:0] opnd, output bit ok);
    int w;
    ok = 1'b0;
    @(negedge clk);
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) begin chk("ready_timeout", 32'd0, 32'd1); return; end
    req_op = 4'(op); req_operand = opnd; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; req_op = 4'($urandom); req_operand = 16'($urandom);
    ok = 1'b1;
  endtask

  task automatic run_op(input int op, input logic [15:0] opnd, input int hold);
    bit ok, got;
    int k;
    logic [31:0] r;
    logic [15:0] acc0;
    accept(op, opnd, ok);
    if (!ok) return;
    got = 1'b0;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      chk("ctrl", control_signal, exp_ctrl(op, k));
      if (rsp_valid) begin got = 1'b1; break; end
    end
    if (!got) begin chk("rsp_timeout", 32'd0, 32'd1); return; end
    chk("latency", 32'(k), 32'(exp_lat(op)));
    if (op == 14) ref_br = opnd;
    else if (op != 15) begin
      if (is_bin(op)) ref_br = opnd;
      r = op_res(op, ref_acc, ref_high, ref_br);
      {ref_high, ref_acc} = r;
    end
    chk("rsp_acc", 32'(rsp_acc), 32'(ref_acc));
    chk("rsp_high", 32'(rsp_high), 32'(ref_high));
    chk("rsp_flag", 32'(rsp_flag), 32'(ref_acc[15]));
    chk("rsp_err", 32'(rsp_err), 32'(op == 15));
    chk("br_out", 32'(br_out), 32'(opnd));
    acc0 = rsp_acc;
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_acc", 32'(rsp_acc), 32'(acc0));
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_ctrl", control_signal, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("after_valid", 32'(rsp_valid), 32'd0);
    chk("after_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit ok;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_op = '0; req_operand = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", control_signal, 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_acc", 32'(rsp_acc), 32'd0);
    chk("rst_br", 32'(br_out), 32'd0);
    rst_n = 1'b1;

    run_op(0, 16'h0, 0);
    run_op(1, 16'd5, 0);
    run_op(2, 16'd7, 0);
    run_op(0, 16'h0, 0);
    run_op(1, 16'd100, 0);
    run_op(4, 16'd7, 0);
    run_op(15, 16'hBEEF, 0);
    run_op(1, 16'd3, 5);
    run_op(14, 16'h1234, 0);
    run_op(3, 16'd300, 1);

    // Reset in the EXEC cycle of a multiply: the ALU keeps its BR load only.
    accept(3, 16'd77, ok);
    if (ok) begin
      @(negedge clk);
      @(negedge clk);
      chk("mul_exec", control_signal, 32'h1 << 16);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_ctrl", control_signal, 32'd0);
      chk("arst_valid", 32'(rsp_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_br", 32'(br_out), 32'd0);
      ref_br = 16'd77;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(1, 16'd9, 0);
    end

    for (int i = 0; i < 40; i++)
      run_op(int'($urandom_range(0, 15)), 16'($urandom), int'($urandom_range(0, 3)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
